// File: rtl/battleship_pkg.sv
// Shared definitions for the battleship game controller: board size, ship count,
// coordinate width, FSM state encodings and cursor wrap helpers.
package battleship_pkg;

  localparam int GRID      = 5;
  localparam int NUM_SHIPS = 3;
  localparam int COORD_W   = 3;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE         = 3'd0;
  localparam state_t ST_PLACE        = 3'd1;
  localparam state_t ST_ATTACK       = 3'd2;
  localparam state_t ST_CHECK_PC     = 3'd3;
  localparam state_t ST_PC_ATTACK    = 3'd4;
  localparam state_t ST_CHECK_PLAYER = 3'd5;
  localparam state_t ST_DEAD_PC      = 3'd6;
  localparam state_t ST_DEAD_PLAYER  = 3'd7;

  function automatic logic [COORD_W-1:0] wrap_inc(input logic [COORD_W-1:0] v, input int grid);
    return (v == COORD_W'(grid - 1)) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [COORD_W-1:0] wrap_dec(input logic [COORD_W-1:0] v, input int grid);
    return (v == '0) ? COORD_W'(grid - 1) : v - 1'b1;
  endfunction

endpackage

// File: rtl/battleship_game_ctrl_grid_cursor.sv
// One (x,y) board cursor with modulo-GRID wrap; a single move per cycle,
// priority up > down > left > right.
module grid_cursor #(
  parameter int GRID_N = battleship_pkg::GRID
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clr,
  input  logic                               en,
  input  logic                               up,
  input  logic                               down,
  input  logic                               left,
  input  logic                               right,
  output logic [battleship_pkg::COORD_W-1:0] x,
  output logic [battleship_pkg::COORD_W-1:0] y
);
  import battleship_pkg::*;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (up)         y <= wrap_dec(y, GRID_N);
      else if (down)  y <= wrap_inc(y, GRID_N);
      else if (left)  x <= wrap_dec(x, GRID_N);
      else if (right) x <= wrap_inc(x, GRID_N);
    end
  end

endmodule

// File: rtl/battleship_game_ctrl.sv
// Battleship game sequencer: ship placement, timed player attack turns, PC turns
// and life checks, driving phase flags and board write strobes.
module battleship_game_ctrl #(
  parameter int GRID         = battleship_pkg::GRID,
  parameter int NUM_SHIPS    = battleship_pkg::NUM_SHIPS,
  parameter int TURN_TIMEOUT = 30_000_000
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               btn_up,
  input  logic                               btn_down,
  input  logic                               btn_left,
  input  logic                               btn_right,
  input  logic                               btn_sel,
  input  logic                               place_ok,
  input  logic                               attack_ok,
  input  logic                               pc_attack_done,
  input  logic [3:0]                         pc_cells_left,
  input  logic [3:0]                         player_cells_left,
  output logic                               en_put_barcos,
  output logic                               en_attack,
  output logic                               en_pc_attack,
  output logic                               en_check_pc_life,
  output logic                               en_check_player_life,
  output logic                               dead_pc,
  output logic                               dead_player,
  output logic [battleship_pkg::COORD_W-1:0] posicion_x_move,
  output logic [battleship_pkg::COORD_W-1:0] posicion_y_move,
  output logic [battleship_pkg::COORD_W-1:0] posicion_x_attack,
  output logic [battleship_pkg::COORD_W-1:0] posicion_y_attack,
  output logic                               commit_place,
  output logic                               commit_attack,
  output logic [2:0]                         ships_placed
);
  import battleship_pkg::*;

  localparam int TW = $clog2(TURN_TIMEOUT + 1);

  state_t        state_reg, state_next;
  logic [2:0]    ships_reg, ships_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          place_fire, attack_fire, clr_cursors;

  always_comb begin
    state_next  = state_reg;
    ships_next  = ships_reg;
    timer_next  = timer_reg;
    place_fire  = 1'b0;
    attack_fire = 1'b0;
    clr_cursors = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DEAD_PC, ST_DEAD_PLAYER: begin
        if (start) begin
          state_next  = ST_PLACE;
          ships_next  = '0;
          timer_next  = '0;
          clr_cursors = 1'b1;
        end
      end
      ST_PLACE: begin
        if (btn_sel && place_ok) begin
          place_fire = 1'b1;
          ships_next = ships_reg + 3'd1;
          if (ships_reg == 3'(NUM_SHIPS - 1)) begin
            state_next = ST_ATTACK;
            timer_next = '0;
          end
        end
      end
      ST_ATTACK: begin
        timer_next = timer_reg + 1'b1;
        if (btn_sel && attack_ok) begin
          attack_fire = 1'b1;
          state_next  = ST_CHECK_PC;
        end else if (timer_reg == TW'(TURN_TIMEOUT - 1)) begin
          // Turn forfeited: the PC still gets its move.
          state_next = ST_CHECK_PC;
        end
      end
      ST_CHECK_PC:  state_next = (pc_cells_left == 4'd0) ? ST_DEAD_PC : ST_PC_ATTACK;
      ST_PC_ATTACK: if (pc_attack_done) state_next = ST_CHECK_PLAYER;
      ST_CHECK_PLAYER: begin
        if (player_cells_left == 4'd0) begin
          state_next = ST_DEAD_PLAYER;
        end else begin
          state_next = ST_ATTACK;
          timer_next = '0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Flags are decoded from the next state so they are registered yet track the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg            <= ST_IDLE;
      ships_reg            <= '0;
      timer_reg            <= '0;
      commit_place         <= 1'b0;
      commit_attack        <= 1'b0;
      en_put_barcos        <= 1'b0;
      en_attack            <= 1'b0;
      en_check_pc_life     <= 1'b0;
      en_pc_attack         <= 1'b0;
      en_check_player_life <= 1'b0;
      dead_pc              <= 1'b0;
      dead_player          <= 1'b0;
    end else begin
      state_reg            <= state_next;
      ships_reg            <= ships_next;
      timer_reg            <= timer_next;
      commit_place         <= place_fire;
      commit_attack        <= attack_fire;
      en_put_barcos        <= (state_next == ST_PLACE);
      en_attack            <= (state_next == ST_ATTACK);
      en_check_pc_life     <= (state_next == ST_CHECK_PC);
      en_pc_attack         <= (state_next == ST_PC_ATTACK);
      en_check_player_life <= (state_next == ST_CHECK_PLAYER);
      dead_pc              <= (state_next == ST_DEAD_PC);
      dead_player          <= (state_next == ST_DEAD_PLAYER);
    end
  end

  assign ships_placed = ships_reg;

  // A select pulse outranks every move button, so it disables the cursors.
  grid_cursor #(.GRID_N(GRID)) u_move_cursor (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_cursors),
    .en    ((state_reg == ST_PLACE) && !btn_sel),
    .up    (btn_up),
    .down  (btn_down),
    .left  (btn_left),
    .right (btn_right),
    .x     (posicion_x_move),
    .y     (posicion_y_move)
  );

  grid_cursor #(.GRID_N(GRID)) u_attack_cursor (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_cursors),
    .en    ((state_reg == ST_ATTACK) && !btn_sel),
    .up    (btn_up),
    .down  (btn_down),
    .left  (btn_left),
    .right (btn_right),
    .x     (posicion_x_attack),
    .y     (posicion_y_attack)
  );

endmodule

// File: tb/tb_battleship_game_ctrl.sv
// Directed self-checking bench for battleship_game_ctrl (GRID=5, NUM_SHIPS=3, TURN_TIMEOUT=8).
module tb_battleship_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, btn_up, btn_down, btn_left, btn_right, btn_sel;
  logic       place_ok, attack_ok, pc_attack_done;
  logic [3:0] pc_cells_left, player_cells_left;
  logic       en_put_barcos, en_attack, en_pc_attack, en_check_pc_life;
  logic       en_check_player_life, dead_pc, dead_player;
  logic [2:0] posicion_x_move, posicion_y_move, posicion_x_attack, posicion_y_attack;
  logic       commit_place, commit_attack;
  logic [2:0] ships_placed;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [6:0] F_NONE  = 7'b0000000;
  localparam logic [6:0] F_PLACE = 7'b1000000;
  localparam logic [6:0] F_ATT   = 7'b0100000;
  localparam logic [6:0] F_CPC   = 7'b0010000;
  localparam logic [6:0] F_PCA   = 7'b0001000;
  localparam logic [6:0] F_CPL   = 7'b0000100;
  localparam logic [6:0] F_DPC   = 7'b0000010;
  localparam logic [6:0] F_DPL   = 7'b0000001;

  logic [6:0] flags;
  logic [5:0] move_xy, attack_xy;
  assign flags     = {en_put_barcos, en_attack, en_check_pc_life, en_pc_attack,
                      en_check_player_life, dead_pc, dead_player};
  assign move_xy   = {posicion_x_move, posicion_y_move};
  assign attack_xy = {posicion_x_attack, posicion_y_attack};

  always #5 clk = ~clk;

  battleship_game_ctrl #(
    .GRID(5), .NUM_SHIPS(3), .TURN_TIMEOUT(8)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .start                (start),
    .btn_up               (btn_up),
    .btn_down             (btn_down),
    .btn_left             (btn_left),
    .btn_right            (btn_right),
    .btn_sel              (btn_sel),
    .place_ok             (place_ok),
    .attack_ok            (attack_ok),
    .pc_attack_done       (pc_attack_done),
    .pc_cells_left        (pc_cells_left),
    .player_cells_left    (player_cells_left),
    .en_put_barcos        (en_put_barcos),
    .en_attack            (en_attack),
    .en_pc_attack         (en_pc_attack),
    .en_check_pc_life     (en_check_pc_life),
    .en_check_player_life (en_check_player_life),
    .dead_pc              (dead_pc),
    .dead_player          (dead_player),
    .posicion_x_move      (posicion_x_move),
    .posicion_y_move      (posicion_y_move),
    .posicion_x_attack    (posicion_x_attack),
    .posicion_y_attack    (posicion_y_attack),
    .commit_place         (commit_place),
    .commit_attack        (commit_attack),
    .ships_placed         (ships_placed)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock edge with the currently driven inputs; pulse inputs drop afterwards.
  task automatic step(input string name);
    $display("[%0t] txn %s", $time, name);
    @(posedge clk);
    #1;
    start = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    btn_sel = 0; pc_attack_done = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; start = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    btn_sel = 0; place_ok = 0; attack_ok = 0; pc_attack_done = 0;
    pc_cells_left = 4'd5; player_cells_left = 4'd5;
    #12;
    chk("reset_flags", flags, F_NONE);
    chk("reset_cursors", {move_xy, attack_xy}, 12'h000);
    chk("reset_ships", ships_placed, 3'd0);
    chk("reset_commits", {commit_place, commit_attack}, 2'b00);

    @(negedge clk) rst_n = 1;
    step("idle");
    chk("idle_flags", flags, F_NONE);

    start = 1; step("start");
    chk("start_flags", flags, F_PLACE);
    chk("start_cursors", {move_xy, attack_xy}, 12'h000);
    chk("start_ships", ships_placed, 3'd0);

    btn_left = 1; step("left at x=0");
    chk("wrap_left", move_xy, {3'd4, 3'd0});
    btn_up = 1; step("up at y=0");
    chk("wrap_up", move_xy, {3'd4, 3'd4});
    btn_down = 1; step("down at y=4");
    chk("wrap_down", move_xy, {3'd4, 3'd0});
    btn_up = 1; btn_right = 1; step("up+right");
    chk("prio_up_right", move_xy, {3'd4, 3'd4});
    chk("attack_cursor_hold", attack_xy, 6'd0);

    place_ok = 1; btn_sel = 1; step("place 1");
    chk("commit_place_1", commit_place, 1'b1);
    chk("ships_1", ships_placed, 3'd1);
    step("gap");
    chk("commit_place_drop", commit_place, 1'b0);
    place_ok = 0; btn_sel = 1; step("place rejected");
    chk("commit_place_rej", commit_place, 1'b0);
    chk("ships_rej", ships_placed, 3'd1);
    place_ok = 1; btn_sel = 1; btn_left = 1; step("place 2 + left");
    chk("commit_place_2", commit_place, 1'b1);
    chk("ships_2", ships_placed, 3'd2);
    chk("sel_over_left", move_xy, {3'd4, 3'd4});
    btn_sel = 1; step("place 3");
    chk("commit_place_3", commit_place, 1'b1);
    chk("ships_3", ships_placed, 3'd3);
    chk("enter_attack", flags, F_ATT);

    step("attack wait");
    chk("commit_place_off", commit_place, 1'b0);
    btn_right = 1; step("attack right");
    chk("attack_right", attack_xy, {3'd1, 3'd0});
    chk("move_cursor_hold", move_xy, {3'd4, 3'd4});
    attack_ok = 0; btn_sel = 1; step("attack rejected");
    chk("commit_attack_rej", commit_attack, 1'b0);
    chk("attack_rej_flags", flags, F_ATT);
    pc_cells_left = 4'd0; attack_ok = 1; btn_sel = 1; step("attack hit last");
    chk("commit_attack_1", commit_attack, 1'b1);
    chk("check_pc_flags", flags, F_CPC);
    step("check pc");
    chk("commit_attack_drop", commit_attack, 1'b0);
    chk("dead_pc_flags", flags, F_DPC);
    step("dead hold"); step("dead hold");
    chk("dead_pc_hold", flags, F_DPC);

    start = 1; step("restart");
    chk("restart_flags", flags, F_PLACE);
    chk("restart_ships", ships_placed, 3'd0);
    chk("restart_cursors", {move_xy, attack_xy}, 12'h000);
    pc_cells_left = 4'd5; place_ok = 1;
    for (int i = 0; i < 3; i++) begin
      btn_sel = 1; step("place");
    end
    chk("attack_again", flags, F_ATT);
    attack_ok = 0;
    for (int i = 0; i < 7; i++) step("idle attack");
    chk("timeout_not_yet", flags, F_ATT);
    step("timeout");
    chk("timeout_flags", flags, F_CPC);
    chk("timeout_no_commit", commit_attack, 1'b0);
    step("check pc");
    chk("pc_attack_flags", flags, F_PCA);
    step("pc busy");
    chk("pc_attack_hold", flags, F_PCA);
    player_cells_left = 4'd3; pc_attack_done = 1; step("pc done");
    chk("check_player_flags", flags, F_CPL);
    step("check player");
    chk("back_to_attack", flags, F_ATT);
    attack_ok = 1; btn_sel = 1; step("attack");
    chk("commit_attack_2", commit_attack, 1'b1);
    step("check pc");
    chk("pc_attack_2", flags, F_PCA);
    player_cells_left = 4'd0; pc_attack_done = 1; step("pc done last");
    chk("check_player_2", flags, F_CPL);
    step("check player");
    chk("dead_player_flags", flags, F_DPL);
    step("dead hold");
    chk("dead_player_hold", flags, F_DPL);

    start = 1; step("restart");
    player_cells_left = 4'd5;
    btn_right = 1; step("move right");
    for (int i = 0; i < 3; i++) begin
      btn_sel = 1; step("place");
    end
    btn_down = 1; step("attack down");
    chk("attack_down", attack_xy, {3'd0, 3'd1});
    btn_sel = 1; step("attack");
    step("check pc");
    chk("pc_attack_3", flags, F_PCA);
    #2 rst_n = 0;
    #1;
    chk("async_rst_flags", flags, F_NONE);
    chk("async_rst_cursors", {move_xy, attack_xy}, 12'h000);
    chk("async_rst_ships", ships_placed, 3'd0);
    chk("async_rst_commits", {commit_place, commit_attack}, 2'b00);
    @(negedge clk) rst_n = 1;
    step("post reset"); step("post reset");
    chk("post_rst_idle", flags, F_NONE);
    start = 1; step("start");
    chk("post_rst_place", flags, F_PLACE);
    chk("post_rst_ships", ships_placed, 3'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
